// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards from EX/MEM/WB, detects load-use hazards and registers the resolved operands.
// Optional ID_EX_STALL_COUNT_EN adds a 32-bit free-running stall event counter output.
module id_ex_operand_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [REG_W-1:0]  ReadRegister1,
  input  logic [REG_W-1:0]  ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  DestReg,
  input  logic              RegWriteIn,
  input  logic              MemReadIn,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_RegWrite,
  input  logic              ex_MemRead,
  input  logic [REG_W-1:0]  ex_DestReg,
  input  logic [DATA_W-1:0] ex_Result,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic [REG_W-1:0]  mem_DestReg,
  input  logic [DATA_W-1:0] mem_Result,
  input  logic              wb_valid,
  input  logic              wb_RegWrite,
  input  logic [REG_W-1:0]  wb_DestReg,
  input  logic [DATA_W-1:0] wb_Data,
  output logic              stall,
  output logic              out_valid,
  output logic              out_RegWrite,
  output logic              out_MemRead,
  output logic [REG_W-1:0]  out_DestReg,
  output logic [DATA_W-1:0] Op1,
  output logic [DATA_W-1:0] Op2
`ifdef ID_EX_STALL_COUNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  localparam logic [REG_W-1:0] ZERO_REG = '1;

  function automatic logic hit(input logic v, input logic w,
                               input logic [REG_W-1:0] d, input logic [REG_W-1:0] s);
    return v & w & (d == s) & (s != ZERO_REG);
  endfunction

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [DATA_W-1:0] op1_sel, op2_sel;
  logic bubble;

  logic              valid_d, valid_q;
  logic              regwrite_d, regwrite_q;
  logic              memread_d, memread_q;
  logic [REG_W-1:0]  dest_d, dest_q;
  logic [DATA_W-1:0] op1_d, op1_q;
  logic [DATA_W-1:0] op2_d, op2_q;

  always_comb begin
    ex_hit1  = hit(ex_valid,  ex_RegWrite,  ex_DestReg,  ReadRegister1);
    ex_hit2  = hit(ex_valid,  ex_RegWrite,  ex_DestReg,  ReadRegister2);
    mem_hit1 = hit(mem_valid, mem_RegWrite, mem_DestReg, ReadRegister1);
    mem_hit2 = hit(mem_valid, mem_RegWrite, mem_DestReg, ReadRegister2);
    wb_hit1  = hit(wb_valid,  wb_RegWrite,  wb_DestReg,  ReadRegister1);
    wb_hit2  = hit(wb_valid,  wb_RegWrite,  wb_DestReg,  ReadRegister2);
  end

  // Lowest priority first so later assignments win; the regfile read is stale during a WB write.
  always_comb begin
    op1_sel = ReadData1;
    if (wb_hit1)  op1_sel = wb_Data;
    if (mem_hit1) op1_sel = mem_Result;
    if (ex_hit1)  op1_sel = ex_Result;
    if (ReadRegister1 == ZERO_REG) op1_sel = '0;

    op2_sel = ReadData2;
    if (wb_hit2)  op2_sel = wb_Data;
    if (mem_hit2) op2_sel = mem_Result;
    if (ex_hit2)  op2_sel = ex_Result;
    if (ReadRegister2 == ZERO_REG) op2_sel = '0;
  end

  always_comb begin
    stall  = reset & in_valid & ~flush & ex_MemRead & (ex_hit1 | ex_hit2);
    bubble = flush | stall;

    valid_d    = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    dest_d     = '0;
    op1_d      = '0;
    op2_d      = '0;
    if (!bubble) begin
      valid_d    = in_valid;
      regwrite_d = RegWriteIn & in_valid;
      memread_d  = MemReadIn & in_valid;
      dest_d     = DestReg;
      op1_d      = op1_sel;
      op2_d      = op2_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      dest_q     <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      dest_q     <= dest_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_RegWrite = regwrite_q;
  assign out_MemRead  = memread_q;
  assign out_DestReg  = dest_q;
  assign Op1          = op1_q;
  assign Op2          = op2_q;

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_count_d, stall_count_q;

  // Flush suppresses stall, so flushed cycles never count; wraps naturally at 2^32.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table followed by randomized traffic against a reference model.
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        rst, iv;
    logic [4:0]  rs1, rs2;
    logic [63:0] rd1, rd2;
    logic [4:0]  dst;
    logic        rw, mrd, fl;
    logic        exv, exw, exm;
    logic [4:0]  exd;
    logic [63:0] exr;
    logic        mv, mw;
    logic [4:0]  md;
    logic [63:0] mres;
    logic        wv, ww;
    logic [4:0]  wd;
    logic [63:0] wdat;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_stall;
    logic        e_valid;
    logic [63:0] e_op1;
    logic [63:0] e_op2;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, RegWriteIn, MemReadIn, flush;
  logic [4:0]  ReadRegister1, ReadRegister2, DestReg;
  logic [63:0] ReadData1, ReadData2;
  logic        ex_valid, ex_RegWrite, ex_MemRead, mem_valid, mem_RegWrite, wb_valid, wb_RegWrite;
  logic [4:0]  ex_DestReg, mem_DestReg, wb_DestReg;
  logic [63:0] ex_Result, mem_Result, wb_Data;
  logic        stall, out_valid, out_RegWrite, out_MemRead;
  logic [4:0]  out_DestReg;
  logic [63:0] Op1, Op2;
`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .DestReg(DestReg), .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .flush(flush),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_DestReg(ex_DestReg), .ex_Result(ex_Result),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_DestReg(mem_DestReg),
    .mem_Result(mem_Result),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_DestReg(wb_DestReg), .wb_Data(wb_Data),
    .stall(stall), .out_valid(out_valid), .out_RegWrite(out_RegWrite),
    .out_MemRead(out_MemRead), .out_DestReg(out_DestReg), .Op1(Op1), .Op2(Op2)
`ifdef ID_EX_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] cnt_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic stim_t dflt();
    stim_t s;
    s = '0;
    s.rst = 1'b1; s.iv = 1'b1;
    s.rs1 = 5'd3; s.rs2 = 5'd4;
    s.rd1 = 64'h11; s.rd2 = 64'h22;
    s.dst = 5'd1; s.rw = 1'b1;
    return s;
  endfunction

  // Reference: scan producers youngest-first, the first live writer of the source wins.
  function automatic logic [63:0] pick(input stim_t s, input logic [4:0] src, input logic [63:0] rd);
    logic        live[3];
    logic [4:0]  dreg[3];
    logic [63:0] val[3];
    if (src == 5'd31) return 64'd0;
    live = '{s.exv & s.exw, s.mv & s.mw, s.wv & s.ww};
    dreg = '{s.exd, s.md, s.wd};
    val  = '{s.exr, s.mres, s.wdat};
    for (int i = 0; i < 3; i++)
      if (live[i] && dreg[i] == src) return val[i];
    return rd;
  endfunction

  function automatic logic m_stall(input stim_t s);
    logic load_in_ex;
    load_in_ex = s.exv & s.exw & s.exm;
    return s.rst & s.iv & ~s.fl & load_in_ex &
           ((s.rs1 != 5'd31 && s.rs1 == s.exd) || (s.rs2 != 5'd31 && s.rs2 == s.exd));
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst; in_valid = s.iv;
    ReadRegister1 = s.rs1; ReadRegister2 = s.rs2;
    ReadData1 = s.rd1; ReadData2 = s.rd2;
    DestReg = s.dst; RegWriteIn = s.rw; MemReadIn = s.mrd; flush = s.fl;
    ex_valid = s.exv; ex_RegWrite = s.exw; ex_MemRead = s.exm; ex_DestReg = s.exd; ex_Result = s.exr;
    mem_valid = s.mv; mem_RegWrite = s.mw; mem_DestReg = s.md; mem_Result = s.mres;
    wb_valid = s.wv; wb_RegWrite = s.ww; wb_DestReg = s.wd; wb_Data = s.wdat;
  endtask

  // One ID cycle: drive at negedge, check stall mid-cycle, check registered outputs after the edge.
  task automatic apply(input stim_t s);
    logic st, live, bub;
    @(negedge clk);
    drive(s);
    #1;
    st   = m_stall(s);
    live = s.rst;
    bub  = s.fl | st;
    chk("stall", {63'd0, stall}, {63'd0, st});
    @(posedge clk);
    #1;
    if (!s.rst) cnt_exp = 0;
    else if (st) cnt_exp = cnt_exp + 1;
    chk("out_valid",    {63'd0, out_valid},    {63'd0, live & ~bub & s.iv});
    chk("out_RegWrite", {63'd0, out_RegWrite}, {63'd0, live & ~bub & s.iv & s.rw});
    chk("out_MemRead",  {63'd0, out_MemRead},  {63'd0, live & ~bub & s.iv & s.mrd});
    chk("out_DestReg",  {59'd0, out_DestReg},  (live && !bub) ? {59'd0, s.dst} : 64'd0);
    chk("Op1", Op1, (live && !bub) ? pick(s, s.rs1, s.rd1) : 64'd0);
    chk("Op2", Op2, (live && !bub) ? pick(s, s.rs2, s.rd2) : 64'd0);
`ifdef ID_EX_STALL_COUNT_EN
    chk("stall_count", {32'd0, stall_count}, {32'd0, cnt_exp});
`endif
  endtask

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 3))
      0: return 5'd3;
      1: return 5'd4;
      2: return 5'd5;
      default: return 5'd31;
    endcase
  endfunction

  vec_t  tbl[$];
  stim_t s;

  initial begin
    drive(dflt());

    s = dflt(); s.rst = 1'b0; s.rd1 = 64'hAAAA;
    tbl.push_back('{s, 1'b0, 1'b0, 64'h0, 64'h0});
    tbl.push_back('{s, 1'b0, 1'b0, 64'h0, 64'h0});
    s = dflt();
    tbl.push_back('{s, 1'b0, 1'b1, 64'h11, 64'h22});
    s = dflt(); s.rs1 = 5'd5;
    s.exv = 1; s.exw = 1; s.exd = 5'd5; s.exr = 64'h100;
    s.mv = 1;  s.mw = 1;  s.md = 5'd5;  s.mres = 64'h200;
    s.wv = 1;  s.ww = 1;  s.wd = 5'd5;  s.wdat = 64'h300;
    tbl.push_back('{s, 1'b0, 1'b1, 64'h100, 64'h22});
    s.exv = 0;
    tbl.push_back('{s, 1'b0, 1'b1, 64'h200, 64'h22});
    s.mv = 0;
    tbl.push_back('{s, 1'b0, 1'b1, 64'h300, 64'h22});
    s = dflt(); s.rs1 = 5'd31; s.rd1 = 64'hDEAD;
    s.exv = 1; s.exw = 1; s.exm = 1; s.exd = 5'd31; s.exr = 64'h55;
    tbl.push_back('{s, 1'b0, 1'b1, 64'h0, 64'h22});
    s = dflt(); s.dst = 5'd31;
    s.mv = 1; s.mw = 1; s.md = 5'd4; s.mres = 64'h444;
    s.wv = 1; s.ww = 1; s.wd = 5'd4; s.wdat = 64'h555;
    tbl.push_back('{s, 1'b0, 1'b1, 64'h11, 64'h444});
    s = dflt(); s.exv = 1; s.exw = 0; s.exd = 5'd3; s.exr = 64'h99;
    tbl.push_back('{s, 1'b0, 1'b1, 64'h11, 64'h22});
    s = dflt(); s.iv = 0; s.exv = 1; s.exw = 1; s.exm = 1; s.exd = 5'd3; s.exr = 64'h99;
    tbl.push_back('{s, 1'b0, 1'b0, 64'h99, 64'h22});
    // Load-use on rs2: bubble, then the load has moved to MEM and forwards.
    s = dflt(); s.rs2 = 5'd7; s.mrd = 1;
    s.exv = 1; s.exw = 1; s.exm = 1; s.exd = 5'd7; s.exr = 64'hBAD;
    tbl.push_back('{s, 1'b1, 1'b0, 64'h0, 64'h0});
    s.exv = 0; s.mv = 1; s.mw = 1; s.md = 5'd7; s.mres = 64'h77;
    tbl.push_back('{s, 1'b0, 1'b1, 64'h11, 64'h77});
    s = dflt(); s.rs2 = 5'd7;
    s.exv = 1; s.exw = 1; s.exm = 1; s.exd = 5'd7; s.exr = 64'hBAD; s.fl = 1;
    tbl.push_back('{s, 1'b0, 1'b0, 64'h0, 64'h0});
    s = dflt(); s.rs1 = 5'd7;
    s.exv = 1; s.exw = 1; s.exm = 1; s.exd = 5'd7;
    tbl.push_back('{s, 1'b1, 1'b0, 64'h0, 64'h0});
    tbl.push_back('{s, 1'b1, 1'b0, 64'h0, 64'h0});
    s.rst = 0;
    tbl.push_back('{s, 1'b0, 1'b0, 64'h0, 64'h0});

    foreach (tbl[i]) begin
      apply(tbl[i].s);
      chk($sformatf("tbl%0d_stall", i), {63'd0, dut.stall}, {63'd0, tbl[i].e_stall});
      chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_op1", i), Op1, tbl[i].e_op1);
      chk($sformatf("tbl%0d_op2", i), Op2, tbl[i].e_op2);
    end

    for (int n = 0; n < 400; n++) begin
      s = '0;
      s.rst  = ($urandom_range(0, 15) != 0);
      s.iv   = ($urandom_range(0, 3) != 0);
      s.rs1  = rnd_reg();  s.rs2 = rnd_reg();
      s.rd1  = {$urandom, $urandom}; s.rd2 = {$urandom, $urandom};
      s.dst  = 5'($urandom);
      s.rw   = 1'($urandom); s.mrd = 1'($urandom);
      s.fl   = ($urandom_range(0, 7) == 0);
      s.exv  = 1'($urandom); s.exw = 1'($urandom); s.exm = 1'($urandom);
      s.exd  = rnd_reg(); s.exr = {$urandom, $urandom};
      s.mv   = 1'($urandom); s.mw = 1'($urandom);
      s.md   = rnd_reg(); s.mres = {$urandom, $urandom};
      s.wv   = 1'($urandom); s.ww = 1'($urandom);
      s.wd   = rnd_reg(); s.wdat = {$urandom, $urandom};
      apply(s);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
